// File: rtl/grid_write_arbiter.sv
// rtl/grid_write_arbiter.sv - round-robin host/engine arbiter for grid row writes gated by a post-frame window
module grid_write_arbiter #(
  parameter int REG_FILE_SIZE = 24,
  parameter int WIN_CYCLES    = 64
) (
  input  logic        out_stream_aclk,
  input  logic        periph_resetn,
  input  logic        lock_en,
  input  logic        frame_done,
  input  logic        host_req,
  input  logic [4:0]  host_row,
  input  logic [31:0] host_data,
  output logic        host_ack,
  input  logic        eng_req,
  input  logic [4:0]  eng_row,
  input  logic [31:0] eng_data,
  output logic        eng_ack,
  output logic        ack_err,
  output logic        wr_en,
  output logic [4:0]  wr_row,
  output logic [31:0] wr_data,
  output logic        window_open,
  output logic [4:0]  frame_writes
);

  localparam int              WIN_W    = $clog2(WIN_CYCLES + 1);
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WIN_CYCLES);
  localparam logic [5:0]      ROW_LIM  = 6'(REG_FILE_SIZE);

  typedef enum logic [1:0] {CLOSED, ARB, WRITE} state_t;

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic               ptr_q, ptr_d;
  logic               win_eng_q, win_eng_d;
  logic [4:0]         row_q, row_d;
  logic [31:0]        data_q, data_d;
  logic [4:0]         fw_q, fw_d;
  logic               grant_eng;
  logic               in_write;
  logic               row_ok;

  assign window_open  = !lock_en || (win_cnt_q != '0);
  assign in_write     = (state_q == WRITE);
  assign row_ok       = ({1'b0, row_q} < ROW_LIM);
  assign wr_en        = in_write && row_ok;
  assign ack_err      = in_write && !row_ok;
  assign host_ack     = in_write && !win_eng_q;
  assign eng_ack      = in_write && win_eng_q;
  assign wr_row       = row_q;
  assign wr_data      = data_q;
  assign frame_writes = fw_q;

  // ptr_q = 1 means the engine wins a tie.
  assign grant_eng = eng_req && (!host_req || ptr_q);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_eng_d = win_eng_q;
    row_d     = row_q;
    data_d    = data_q;
    win_cnt_d = win_cnt_q;
    fw_d      = fw_q;

    if (frame_done) begin
      win_cnt_d = WIN_LOAD;
    end else if (win_cnt_q != '0) begin
      win_cnt_d = win_cnt_q - 1'b1;
    end

    if (frame_done) begin
      fw_d = wr_en ? 5'd1 : 5'd0;
    end else if (wr_en && (fw_q != 5'd31)) begin
      fw_d = fw_q + 5'd1;
    end

    case (state_q)
      CLOSED: begin
        if (window_open) state_d = ARB;
      end
      ARB: begin
        if (!window_open) begin
          state_d = CLOSED;
        end else if (host_req || eng_req) begin
          state_d   = WRITE;
          win_eng_d = grant_eng;
          row_d     = grant_eng ? eng_row : host_row;
          data_d    = grant_eng ? eng_data : host_data;
          ptr_d     = !grant_eng;
        end
      end
      WRITE: begin
        // The write in flight always completes; the window only decides where we go next.
        state_d = window_open ? ARB : CLOSED;
      end
      default: state_d = CLOSED;
    endcase
  end

  always_ff @(posedge out_stream_aclk) begin
    if (!periph_resetn) begin
      state_q   <= CLOSED;
      win_cnt_q <= '0;
      ptr_q     <= 1'b0;
      win_eng_q <= 1'b0;
      row_q     <= '0;
      data_q    <= '0;
      fw_q      <= '0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      ptr_q     <= ptr_d;
      win_eng_q <= win_eng_d;
      row_q     <= row_d;
      data_q    <= data_d;
      fw_q      <= fw_d;
    end
  end

endmodule

// File: doc/grid_write_arbiter.md
GRID_WRITE_ARBITER -- requirements
Module: grid_write_arbiter

Interface
- REQ-001 Parameter REG_FILE_SIZE, default 24: number of grid rows, 32 bits per row.
- REQ-002 Parameter WIN_CYCLES, default 64: length in cycles of the write window opened by frame_done.
- REQ-003 out_stream_aclk  in  1: sole clock; all logic on its rising edge.
- REQ-004 periph_resetn  in  1: reset, synchronous, active-low.
- REQ-005 lock_en  in  1: 1 limits writes to the post-frame window; 0 keeps the window always open.
- REQ-006 frame_done  in  1: one-cycle pulse on the last pixel of a frame.
- REQ-007 host_req  in  1 / host_row  in  5 / host_data  in  32: host row-write request.
- REQ-008 host_ack  out  1: one-cycle completion strobe for the host.
- REQ-009 eng_req  in  1 / eng_row  in  5 / eng_data  in  32: update-engine row-write request.
- REQ-010 eng_ack  out  1: one-cycle completion strobe for the engine.
- REQ-011 ack_err  out  1: valid with either ack; 1 = row >= REG_FILE_SIZE, no write done.
- REQ-012 wr_en  out  1 / wr_row  out  5 / wr_data  out  32: grid register-file write port.
- REQ-013 window_open  out  1: writes are currently permitted.
- REQ-014 frame_writes  out  5: committed writes since the last frame_done, saturating at 31.

Function
- REQ-015 The FSM SHALL have three states: CLOSED, ARB and WRITE.
- REQ-016 window_open = (lock_en==0) or (win_cnt != 0); win_cnt is CLOG2(WIN_CYCLES+1) bits wide.
- REQ-017 frame_done SHALL load win_cnt = WIN_CYCLES in any state; otherwise win_cnt decrements by 1 when nonzero.
- REQ-018 CLOSED: go to ARB the cycle after window_open becomes 1; ignore all requests while closed.
- REQ-019 ARB with window closed: go to CLOSED; no grant issued.
- REQ-020 ARB with window open and any req: select one requester, latch its row and data, go to WRITE.
- REQ-021 Arbitration SHALL be round-robin with a 1-bit priority pointer (reset: host first).
  - Single request: that requester wins.
  - Both requesting: the pointer's requester wins.
  - After every grant, the pointer moves to the loser.
- REQ-022 WRITE lasts exactly one cycle and asserts the winner's ack.
  - Row < REG_FILE_SIZE: wr_en=1 with the latched row and data; ack_err=0; frame_writes +1.
  - Otherwise: wr_en=0 and ack_err=1.
- REQ-023 From WRITE, go to ARB if the window is open, else CLOSED; a window closing during WRITE SHALL NOT abort that write.
- REQ-024 Latency: req sampled in ARB at edge N; wr_en/ack high during cycle N+1; a continuous single requester gets at most one write every 2 cycles.
- REQ-025 Requesters SHALL hold req, row and data stable until ack and drop req at the edge where ack is high; req is ignored in WRITE.
- REQ-026 wr_en, host_ack and eng_ack SHALL never be high for more than one consecutive cycle, and host_ack and eng_ack SHALL never be high together.
- REQ-027 frame_done SHALL clear frame_writes; if a write commits in the same cycle, frame_writes = 1.
- REQ-028 lock_en changes SHALL take effect on window_open in the same cycle, and the FSM reacts on the next edge.

Reset
- REQ-029 With periph_resetn=0 at an edge, the block SHALL set:
  - state = CLOSED, win_cnt = 0, pointer = host;
  - frame_writes = 0, wr_en = 0, host_ack = eng_ack = 0, ack_err = 0.
- REQ-030 Reset during WRITE SHALL suppress that write and its ack from the next cycle onward.
- REQ-031 With lock_en=1 after reset, no write SHALL occur until the first frame_done.

Verification
- REQ-032 lock_en=0, host_req row 3 data 0xA5A5A5A5 -> two cycles later wr_en=1, wr_row=3, wr_data=0xA5A5A5A5, host_ack=1, ack_err=0, frame_writes=1.
- REQ-033 lock_en=0, host and engine requesting continuously after reset -> grants alternate host, eng, host, eng; one wr_en every 2 cycles; acks never overlap.
- REQ-034 lock_en=1, eng_req held with no frame_done for 200 cycles -> wr_en stays 0; after frame_done, grant arrives within 3 cycles.
- REQ-035 lock_en=1, WIN_CYCLES=64, host streams rows 0..23 from frame_done -> exactly the writes started before win_cnt reaches 0 commit (max 32); the rest wait for the next frame_done.
- REQ-036 host_row=24 -> host_ack=1, ack_err=1, wr_en=0, frame_writes unchanged.
- REQ-037 periph_resetn driven low in the WRITE cycle, then released -> no ack follows, all outputs at reset values, first grant goes to host.
